i2c_byte_master: RTL and testbench

- Synthesizable byte-level I2C master that drives the open-drain SCL/SDA bus toward the slave-side bus functional interface in the I2C verification environment.
- Accepts one bus command per valid/ready handshake: START, WRITE byte, READ byte, or STOP.
- Generates bit-level SCL/SDA sequencing from a quarter-period tick divider.
- Returns one response per command: read data, slave ACK/NACK, or a protocol error.

---
 rtl/i2c_byte_master.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master driving open-drain SCL/SDA.
//
// One command per cmd_valid/cmd_ready handshake (START, WRITE, READ, STOP).
// Each command produces one rsp_valid pulse. Bit timing comes from a divider
// that splits every SCL bit into four quarter phases of CLK_DIV clocks each.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00=START 01=WRITE 10=READ 11=STOP
//   cmd_data              byte for WRITE
//   cmd_ack_en            READ: 1 = master ACKs the byte, 0 = master NACKs
//   rsp_valid             one-cycle completion pulse
//   rsp_data              received byte (READ), 0 otherwise; held between responses
//   rsp_nack              WRITE: slave ACK bit (1 = NACK), 0 otherwise; held
//   rsp_err               command illegal in the current bus state
//   bus_held              master owns the bus (between START and STOP)
//   scl_i/sda_i           sampled bus lines
//   scl_o/sda_o           0 = pull line low, 1 = release
//
// Optional build macro:
//   I2C_CLK_STRETCH_EN    honour slave clock stretching: the divider freezes at the
//                         start of any phase where SCL is released until scl_i is high.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_ack_en,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_nack,
  output logic                  rsp_err,
  output logic                  bus_held,
  input  logic                  scl_i,
  output logic                  scl_o,
  input  logic                  sda_i,
  output logic                  sda_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {OpStart = 2'b00, OpWrite = 2'b01, OpRead = 2'b10, OpStop = 2'b11} op_e;

  typedef enum logic [2:0] {
    StIdle, StHeld, StStartQ, StWbit, StRbit, StAckQ, StStopQ, StResp
  } state_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [1:0]            phase_q, phase_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d;
  logic                  ack_en_q, ack_en_d;
  logic                  rep_q, rep_d;
  logic                  err_q, err_d;
  logic                  nack_q, nack_d;
  logic                  held_q, held_d;

  logic                  rsp_valid_q, rsp_err_q, rsp_nack_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic busy, freeze, tick, sample, phase_end, accept, line_bit;

  assign busy      = (state_q == StStartQ) || (state_q == StWbit) || (state_q == StRbit) ||
                     (state_q == StAckQ) || (state_q == StStopQ);
  assign cmd_ready = (state_q == StIdle) || (state_q == StHeld);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = busy && !freeze && (div_q == DivMax);
  // SDA is sampled on the last clock of Q2, while SCL has been high for a full phase.
  assign sample    = tick && (phase_q == 2'd2);
  assign phase_end = tick && (phase_q == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
  // Q1 is where SCL goes 0->1, except a START from idle where SCL was already released.
  logic scl_rise_phase;
  assign scl_rise_phase = busy && (phase_q == 2'd1) && !((state_q == StStartQ) && !rep_q);
  assign freeze         = scl_rise_phase && (div_q == '0) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign freeze     = 1'b0;
`endif

  // Value driven on SDA during a data or acknowledge bit.
  always_comb begin
    line_bit = 1'b1;
    unique case (state_q)
      StWbit:  line_bit = tx_q[DATA_WIDTH-1];
      StAckQ:  line_bit = (op_q == OpRead) ? ~ack_en_q : 1'b1;
      default: line_bit = 1'b1;
    endcase
  end

  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    unique case (state_q)
      StHeld: begin
        scl_o = 1'b0;
        sda_o = 1'b0;
      end
      StResp: begin
        // Lines already settle to where the next state (HELD or IDLE) leaves them.
        scl_o = ~held_q;
        sda_o = ~held_q;
      end
      StStartQ: begin
        unique case (phase_q)
          2'd0:    scl_o = ~rep_q;
          2'd1:    scl_o = 1'b1;
          2'd2:    sda_o = 1'b0;
          default: begin
            scl_o = 1'b0;
            sda_o = 1'b0;
          end
        endcase
      end
      StStopQ: begin
        unique case (phase_q)
          2'd0: begin
            scl_o = 1'b0;
            sda_o = 1'b0;
          end
          2'd1:    sda_o = 1'b0;
          default: sda_o = 1'b1;
        endcase
      end
      StWbit, StRbit, StAckQ: begin
        scl_o = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_o = line_bit;
      end
      default: begin
        scl_o = 1'b1;
        sda_o = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    ack_en_d = ack_en_q;
    rep_d    = rep_q;
    err_d    = err_q;
    nack_d   = nack_q;
    held_d   = held_q;

    if (busy && !freeze) begin
      if (tick) begin
        div_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (sample) begin
      if (state_q == StRbit) rx_d = {rx_q[DATA_WIDTH-2:0], sda_i};
      if (state_q == StAckQ) nack_d = sda_i;
    end

    unique case (state_q)
      StIdle, StHeld: begin
        if (accept) begin
          op_d     = op_e'(cmd_op);
          tx_d     = cmd_data;
          ack_en_d = cmd_ack_en;
          div_d    = '0;
          phase_d  = '0;
          bit_d    = '0;
          rep_d    = (state_q == StHeld);
          err_d    = 1'b0;
          nack_d   = 1'b0;
          if ((state_q == StIdle) && (op_e'(cmd_op) != OpStart)) begin
            // No bus activity; answer with an error next cycle.
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            unique case (op_e'(cmd_op))
              OpStart: state_d = StStartQ;
              OpWrite: state_d = StWbit;
              OpRead:  state_d = StRbit;
              default: state_d = StStopQ;
            endcase
          end
        end
      end
      StStartQ: begin
        if (phase_end) begin
          state_d = StResp;
          held_d  = 1'b1;
        end
      end
      StWbit: begin
        if (phase_end) begin
          tx_d = tx_q << 1;
          if (bit_q == BitMax) state_d = StAckQ;
          else                 bit_d   = bit_q + 1'b1;
        end
      end
      StRbit: begin
        if (phase_end) begin
          if (bit_q == BitMax) state_d = StAckQ;
          else                 bit_d   = bit_q + 1'b1;
        end
      end
      StAckQ: begin
        if (phase_end) state_d = StResp;
      end
      StStopQ: begin
        if (phase_end) begin
          state_d = StResp;
          held_d  = 1'b0;
        end
      end
      StResp:  state_d = held_q ? StHeld : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpStart;
      div_q       <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ack_en_q    <= 1'b0;
      rep_q       <= 1'b0;
      err_q       <= 1'b0;
      nack_q      <= 1'b0;
      held_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ack_en_q    <= ack_en_d;
      rep_q       <= rep_d;
      err_q       <= err_d;
      nack_q      <= nack_d;
      held_q      <= held_d;
      // Response is registered out of RESP so it coincides with cmd_ready returning.
      rsp_valid_q <= (state_q == StResp);
      rsp_err_q   <= (state_q == StResp) && err_q;
      if (state_q == StResp) begin
        rsp_data_q <= ((op_q == OpRead) && !err_q) ? rx_q : '0;
        rsp_nack_q <= (op_q == OpWrite) && !err_q && nack_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_data  = rsp_data_q;
  assign bus_held  = held_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: a bus-level slave model on the open-drain
// lines plus a command-level reference model of responses, latencies and bus events.
module tb_i2c_byte_master;

  localparam int unsigned ClkDiv = 4;
  localparam logic [1:0] OpStart = 2'd0, OpWrite = 2'd1, OpRead = 2'd2, OpStop = 2'd3;
  localparam logic [1:0] SlvNone = 2'd0, SlvAck = 2'd1, SlvRead = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ack_en = 1'b0;
  logic       rsp_valid, rsp_nack, rsp_err, bus_held;
  logic [7:0] rsp_data;
  logic       scl_o, sda_o, scl_line, sda_line, slave_sda;

  int n_checks = 0;
  int n_fail = 0;

  // Slave model state
  logic [1:0] slv_mode = 2'd0;
  logic [7:0] slv_byte = 8'd0;
  logic [7:0] slv_sh = 8'd0;
  int         slv_bit = 0;
  logic       slv_skip = 1'b0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic [8:0] slv_q[$];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         low_cnt = 0;

  // Reference model state
  logic held_m = 1'b0;

  always #5 clk = ~clk;

  assign scl_line  = scl_o;
  assign slave_sda = (slv_mode == SlvRead && slv_bit < 8) ? slv_byte[3'(7 - slv_bit)] :
                     (slv_mode == SlvAck && slv_bit == 8) ? 1'b0 : 1'b1;
  assign sda_line  = sda_o & slave_sda;

  i2c_byte_master #(.CLK_DIV(ClkDiv), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ack_en (cmd_ack_en),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_nack   (rsp_nack),
    .rsp_err    (rsp_err),
    .bus_held   (bus_held),
    .scl_i      (scl_line),
    .scl_o      (scl_o),
    .sda_i      (sda_line),
    .sda_o      (sda_o)
  );

  // Bus-level slave: START/STOP detection, bit counting on SCL falling edges,
  // byte plus 9th-bit capture on SCL rising edges.
  always @(scl_line or sda_line) begin
    if (scl_line === 1'b1 && scl_prev === 1'b1) begin
      if (sda_prev === 1'b1 && sda_line === 1'b0) begin
        start_cnt++;
        slv_bit  = 0;
        slv_skip = 1'b1;
      end
      if (sda_prev === 1'b0 && sda_line === 1'b1) stop_cnt++;
    end
    if (scl_line === 1'b1 && scl_prev === 1'b0) begin
      if (slv_bit < 8) slv_sh = {slv_sh[6:0], sda_line};
      else             slv_q.push_back({slv_sh, sda_line});
    end
    if (scl_line === 1'b0 && scl_prev === 1'b1) begin
      if (slv_skip) slv_skip = 1'b0;
      else          slv_bit = (slv_bit == 8) ? 0 : slv_bit + 1;
    end
    scl_prev = scl_line;
    sda_prev = sda_line;
  end

  always @(posedge clk) begin
    if (!rst && (scl_o === 1'b0 || sda_o === 1'b0)) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack_en,
                        input logic [1:0] mode, input logic [7:0] sbyte);
    int         n, lat, st0, sp0, lo0;
    logic       err, exp_nack;
    logic [7:0] exp_data, line_byte;
    logic [8:0] rec, exp_rec;
    err       = !held_m && (op != OpStart);
    lat       = err ? 1 : ((op == OpWrite || op == OpRead) ? 36 * ClkDiv + 1 : 4 * ClkDiv + 1);
    line_byte = (mode == SlvRead) ? sbyte : 8'hFF;
    exp_data  = (op == OpRead && !err) ? line_byte : 8'h00;
    exp_nack  = (op == OpWrite && !err) && (mode != SlvAck);
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    slv_mode = err ? SlvNone : mode;
    slv_byte = sbyte;
    st0 = start_cnt;
    sp0 = stop_cnt;
    lo0 = low_cnt;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_data   = data;
    cmd_ack_en = ack_en;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the DUT must use the latched copies.
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_data   = 8'($urandom);
    cmd_ack_en = 1'($urandom);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_nack", 32'(rsp_nack), 32'(exp_nack));
    if (!err && op == OpStart) held_m = 1'b1;
    if (!err && op == OpStop)  held_m = 1'b0;
    check("bus_held", 32'(bus_held), 32'(held_m));
    check("start_seen", 32'(start_cnt - st0), 32'(!err && op == OpStart));
    check("stop_seen", 32'(stop_cnt - sp0), 32'(!err && op == OpStop));
    if (!err && (op == OpWrite || op == OpRead)) begin
      check("slv_count", 32'(slv_q.size()), 32'd1);
      exp_rec = (op == OpWrite) ? {data, (mode != SlvAck)} : {line_byte, ~ack_en};
      if (slv_q.size() > 0) begin
        rec = slv_q.pop_front();
        check("slv_byte", 32'(rec), 32'(exp_rec));
      end
    end else begin
      check("slv_quiet", 32'(slv_q.size()), 32'd0);
    end
    if (err) check("err_no_bus", 32'(low_cnt - lo0), 32'd0);
    if (!held_m) check("lines_idle", 32'({scl_o, sda_o}), 32'd3);
    check("cmd_ready_rsp", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rsp_hold", 32'({rsp_data, rsp_nack}), 32'({exp_data, exp_nack}));
    slv_mode = SlvNone;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int rsp_seen;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_lines", 32'({scl_o, sda_o}), 32'd3);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp", 32'({rsp_valid, rsp_data, rsp_nack, rsp_err, bus_held}), 32'd0);

    // START then address write 0x44 (address 0x22, write), slave ACKs
    do_cmd(OpStart, 8'h00, 1'b0, SlvNone, 8'h00);
    do_cmd(OpWrite, 8'h44, 1'b0, SlvAck, 8'h00);
    do_cmd(OpWrite, 8'h78, 1'b0, SlvAck, 8'h00);
    do_cmd(OpWrite, 8'hAB, 1'b0, SlvAck, 8'h00);
    do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    // Reads with master ACK then NACK
    do_cmd(OpStart, 8'h00, 1'b0, SlvNone, 8'h00);
    do_cmd(OpWrite, 8'h45, 1'b0, SlvAck, 8'h00);
    do_cmd(OpRead, 8'h00, 1'b1, SlvRead, 8'h5A);
    do_cmd(OpRead, 8'h00, 1'b0, SlvRead, 8'hC3);
    do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    // No slave: NACK keeps the bus held, STOP still legal
    do_cmd(OpStart, 8'h00, 1'b0, SlvNone, 8'h00);
    do_cmd(OpWrite, 8'h90, 1'b0, SlvNone, 8'h00);
    do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    // Illegal commands from idle
    do_cmd(OpWrite, 8'h11, 1'b0, SlvAck, 8'h00);
    do_cmd(OpRead, 8'h00, 1'b1, SlvRead, 8'h33);
    do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    // Reset in the middle of bit 4 of a WRITE
    do_cmd(OpStart, 8'h00, 1'b0, SlvNone, 8'h00);
    slv_mode   = SlvAck;
    cmd_valid  = 1'b1;
    cmd_op     = OpWrite;
    cmd_data   = 8'hA5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (16 * ClkDiv + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_lines", 32'({scl_o, sda_o}), 32'd3);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_held", 32'(bus_held), 32'd0);
    held_m   = 1'b0;
    slv_mode = SlvNone;
    rsp_seen = 0;
    if (rsp_valid === 1'b1) rsp_seen++;
    repeat (40 * ClkDiv) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    check("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
    slv_q.delete();
    do_cmd(OpStart, 8'h00, 1'b0, SlvNone, 8'h00);
    do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    // Randomized command stream, including repeated STARTs and occasional errors
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [1:0] mode;
      op = 2'($urandom_range(0, 3));
      if (!held_m && op != OpStart && $urandom_range(0, 3) != 0) op = OpStart;
      mode = (op == OpRead) ? SlvRead : (($urandom_range(0, 7) == 0) ? SlvNone : SlvAck);
      do_cmd(op, 8'($urandom), 1'($urandom), mode, 8'($urandom));
    end
    if (held_m) do_cmd(OpStop, 8'h00, 1'b0, SlvNone, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
